// File: rtl/llc_fsm_mb.sv
// Multi-buffer LLC control FSM: transmit handshake sequencing and distribution of received frames over NUM_RXBUF buffers.
// Optional build macro LLC_PROMISCUOUS_EN adds the promiscous input (accept every frame into any buffer).
module llc_fsm_mb #(
  parameter int NUM_RXBUF = 4,
  parameter int SELW      = 2,
  parameter int TOW       = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 initreqr,
  input  logic                 traregbit,
  input  logic                 sucftranc,
  input  logic                 sucfrecvc,
  input  logic [NUM_RXBUF-1:0] equal,
  input  logic [NUM_RXBUF-1:0] rxfull,
`ifdef LLC_PROMISCUOUS_EN
  input  logic                 promiscous,
`endif
  input  logic [TOW-1:0]       txto_lim,
  output logic                 activtreg,
  output logic [NUM_RXBUF-1:0] activrreg,
  output logic                 ldrecid,
  output logic                 activgreg,
  output logic [SELW-1:0]      rxbufsel,
  output logic                 sucftrano,
  output logic                 sucfrecvo,
  output logic                 overflowo,
  output logic                 trans,
  output logic                 load,
  output logic                 actvtsft,
  output logic                 actvtcap,
  output logic                 txabort,
  output logic                 resettra,
  output logic                 resetall
);

  typedef enum logic [3:0] {
    IDLE, RESET, TXDRV, TXCAP, TXSFT, TXWAIT, TXDONE, TXABRT, RXWR, RXHOLD
  } state_t;

  state_t               state, state_d;
  logic                 tx_pend, txdone_pend, ovf;
  logic [SELW-1:0]      sel;
  logic [TOW-1:0]       cnt;

  logic [NUM_RXBUF-1:0] acc, avail;
  logic                 match, free_hit, rx_event, tmo;
  logic [SELW-1:0]      free_idx, any_idx;

`ifdef LLC_PROMISCUOUS_EN
  assign acc = promiscous ? '1 : equal;
`else
  assign acc = equal;
`endif
  assign avail = acc & ~rxfull;
  assign match = |acc;

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    any_idx  = '0;
    for (int i = NUM_RXBUF - 1; i >= 0; i--) begin
      if (avail[i]) begin
        free_hit = 1'b1;
        free_idx = SELW'(i);
      end
      if (acc[i]) any_idx = SELW'(i);
    end
  end

  assign rx_event = sucfrecvc && (state == IDLE || state == TXWAIT);
  // >= rather than == so a counter that passed the limit during a reception still aborts.
  assign tmo      = (txto_lim != '0) && (cnt >= txto_lim - TOW'(1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      tx_pend     <= 1'b0;
      txdone_pend <= 1'b0;
      ovf         <= 1'b0;
      sel         <= '0;
      cnt         <= '0;
    end else begin
      state <= state_d;
      if (rx_event && match) begin
        sel <= free_hit ? free_idx : any_idx;
        ovf <= !free_hit;
      end
      case (state)
        RESET:  begin tx_pend <= 1'b0; txdone_pend <= 1'b0; end
        TXDRV:  tx_pend <= 1'b1;
        TXSFT:  cnt <= '0;
        TXWAIT: begin
          cnt <= cnt + TOW'(1);
          if (sucfrecvc) txdone_pend <= sucftranc;
        end
        TXDONE: begin tx_pend <= 1'b0; txdone_pend <= 1'b0; end
        TXABRT: tx_pend <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state;
    activtreg = 1'b0;
    activrreg = '0;
    ldrecid   = 1'b0;
    activgreg = 1'b0;
    rxbufsel  = '0;
    sucftrano = 1'b0;
    sucfrecvo = 1'b0;
    overflowo = 1'b0;
    trans     = 1'b0;
    load      = 1'b0;
    actvtsft  = 1'b0;
    actvtcap  = 1'b0;
    txabort   = 1'b0;
    resettra  = 1'b1;
    resetall  = 1'b1;
    case (state)
      IDLE: begin
        if (rx_event)       state_d = match ? RXWR : RXHOLD;
        else if (traregbit) state_d = TXDRV;
      end
      RESET: begin
        activgreg = 1'b1;
        resetall  = 1'b0;
        state_d   = IDLE;
      end
      TXDRV: state_d = TXCAP;
      TXCAP: begin
        load     = 1'b1;
        actvtcap = 1'b1;
        state_d  = TXSFT;
      end
      TXSFT: begin
        load     = 1'b1;
        actvtsft = 1'b1;
        state_d  = TXWAIT;
      end
      TXWAIT: begin
        trans = 1'b1;
        if (sucfrecvc)      state_d = match ? RXWR : RXHOLD;
        else if (sucftranc) state_d = TXDONE;
        else if (tmo)       state_d = TXABRT;
      end
      TXDONE: begin
        activtreg = 1'b1;
        activgreg = 1'b1;
        sucftrano = 1'b1;
        state_d   = IDLE;
      end
      TXABRT: begin
        resettra = 1'b0;
        txabort  = 1'b1;
        state_d  = IDLE;
      end
      RXWR: begin
        activrreg = NUM_RXBUF'(1) << sel;
        ldrecid   = 1'b1;
        activgreg = 1'b1;
        sucfrecvo = 1'b1;
        overflowo = ovf;
        rxbufsel  = sel;
        state_d   = RXHOLD;
      end
      RXHOLD: begin
        rxbufsel = sel;
        if (!sucfrecvc) begin
          if (txdone_pend)  state_d = TXDONE;
          else if (tx_pend) state_d = TXWAIT;
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (initreqr && state != RESET) state_d = RESET;
  end

endmodule

// File: tb/tb_llc_fsm_mb.sv
// Self-checking bench for llc_fsm_mb: directed scenarios plus randomized frames/transmits against a transaction-level model.
module tb_llc_fsm_mb;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int TW = 16;

  logic          clock = 1'b0, reset = 1'b0, initreqr = 1'b0, traregbit = 1'b0;
  logic          sucftranc = 1'b0, sucfrecvc = 1'b0;
  logic [N-1:0]  equal = '0, rxfull = '0;
  logic [TW-1:0] txto_lim = '0;
  logic          activtreg, ldrecid, activgreg, sucftrano, sucfrecvo, overflowo;
  logic          trans, load, actvtsft, actvtcap, txabort, resettra, resetall;
  logic [N-1:0]  activrreg;
  logic [SW-1:0] rxbufsel;

  int n_assert = 0, n_fail = 0;

  always #5 clock = ~clock;

  llc_fsm_mb #(.NUM_RXBUF(N), .SELW(SW), .TOW(TW)) dut (
    .clock(clock), .reset(reset), .initreqr(initreqr), .traregbit(traregbit),
    .sucftranc(sucftranc), .sucfrecvc(sucfrecvc), .equal(equal), .rxfull(rxfull),
`ifdef LLC_PROMISCUOUS_EN
    .promiscous(1'b0),
`endif
    .txto_lim(txto_lim), .activtreg(activtreg), .activrreg(activrreg), .ldrecid(ldrecid),
    .activgreg(activgreg), .rxbufsel(rxbufsel), .sucftrano(sucftrano), .sucfrecvo(sucfrecvo),
    .overflowo(overflowo), .trans(trans), .load(load), .actvtsft(actvtsft), .actvtcap(actvtcap),
    .txabort(txabort), .resettra(resettra), .resetall(resetall)
  );

  typedef struct packed {
    logic activtreg; logic [N-1:0] activrreg; logic ldrecid; logic activgreg;
    logic [SW-1:0] rxbufsel; logic sucftrano; logic sucfrecvo; logic overflowo;
    logic trans; logic load; logic actvtsft; logic actvtcap; logic txabort;
    logic resettra; logic resetall;
  } outs_t;

  outs_t obs;
  assign obs = {activtreg, activrreg, ldrecid, activgreg, rxbufsel, sucftrano, sucfrecvo,
                overflowo, trans, load, actvtsft, actvtcap, txabort, resettra, resetall};

  function automatic outs_t quiet();
    outs_t o = '0;
    o.resettra = 1'b1;
    o.resetall = 1'b1;
    return o;
  endfunction

  // Buffer choice from the acceptance rules: lowest free match, else lowest match with overflow.
  function automatic void pick(input logic [N-1:0] eq, input logic [N-1:0] full,
                               output bit hit, output int sel, output bit ovf);
    logic [N-1:0] cand;
    hit  = (eq != '0);
    cand = eq & ~full;
    ovf  = 1'b0;
    if (cand == '0) begin
      cand = eq;
      ovf  = 1'b1;
    end
    cand = cand & (~cand + N'(1));
    sel  = (cand == '0) ? 0 : $countones(cand - N'(1));
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_o(input string tag, input outs_t e);
    chk(tag, 32'(obs), 32'(e));
  endtask

  task automatic chk_nowrite(input string tag);
    chk(tag, 32'({activrreg, ldrecid, activgreg, sucfrecvo}), 32'(0));
  endtask

  // IDLE -> TXDRV -> TXCAP -> TXSFT -> first TXWAIT cycle.
  task automatic tx_head();
    outs_t e;
    traregbit = 1'b1;
    step; chk_o("txdrv", quiet());
    step; e = quiet(); e.load = 1'b1; e.actvtcap = 1'b1; chk_o("txcap", e);
    step; e = quiet(); e.load = 1'b1; e.actvtsft = 1'b1; chk_o("txsft", e);
    step; e = quiet(); e.trans = 1'b1; chk_o("txwait", e);
  endtask

  task automatic tx_wait(input int n);
    outs_t e;
    e = quiet(); e.trans = 1'b1;
    repeat (n) begin step; chk_o("txwait_n", e); end
  endtask

  task automatic tx_finish();
    outs_t e;
    sucftranc = 1'b1;
    step; e = quiet(); e.activtreg = 1'b1; e.activgreg = 1'b1; e.sucftrano = 1'b1; chk_o("txdone", e);
    sucftranc = 1'b0; traregbit = 1'b0;
    step; chk_o("tx_idle", quiet());
  endtask

  // One frame, sucfrecvc high for h sampled edges; returns with sucfrecvc low, one edge before exit.
  task automatic rx_frame(input logic [N-1:0] eq, input logic [N-1:0] full, input int h);
    bit hit, ovf; int sel; outs_t e, eh;
    pick(eq, full, hit, sel, ovf);
    equal = eq; rxfull = full; sucfrecvc = 1'b1;
    e = quiet(); e.activrreg = N'(1) << sel; e.ldrecid = 1'b1; e.activgreg = 1'b1;
    e.sucfrecvo = 1'b1; e.overflowo = ovf; e.rxbufsel = SW'(sel);
    eh = quiet(); eh.rxbufsel = SW'(sel);
    step;
    if (hit) chk_o("rxwr", e); else chk_nowrite("rx_miss");
    repeat (h - 1) begin
      step;
      if (hit) chk_o("rxhold", eh); else chk_nowrite("rx_miss_hold");
    end
    sucfrecvc = 1'b0;
    if (hit && h == 1) begin step; chk_o("rxhold1", eh); end
  endtask

  // Transmit without completion: abort expected after lim TXWAIT cycles; optional frame at TXWAIT cycle j.
  task automatic tx_timeout(input int lim, input int j);
    int cnt; outs_t e;
    txto_lim = TW'(lim);
    tx_head;
    cnt = 1;
    if (j > 0) begin
      repeat (j - 1) begin step; cnt++; end
      rx_frame(4'b0001, 4'b0000, 2);
      step; cnt++;
      e = quiet(); e.trans = 1'b1; chk_o("to_resume", e);
    end
    for (int g = 0; g < 100 && obs.trans === 1'b1; g++) begin
      step;
      if (obs.trans === 1'b1) cnt++;
    end
    chk("to_cycles", cnt, lim);
    e = quiet(); e.txabort = 1'b1; e.resettra = 1'b0; chk_o("txabrt", e);
    step; chk_o("abrt_idle", quiet());
    step; chk_o("retry_drv", quiet());
    step; e = quiet(); e.load = 1'b1; e.actvtcap = 1'b1; chk_o("retry_cap", e);
    initreqr = 1'b1;
    step; e = quiet(); e.activgreg = 1'b1; e.resetall = 1'b0; chk_o("cleanup_reset", e);
    initreqr = 1'b0; traregbit = 1'b0; txto_lim = '0;
    step; chk_o("cleanup_idle", quiet());
  endtask

  initial begin
    outs_t e;
    int lim, j, kind;

    // Reset with initreqr asserted.
    reset = 1'b0; initreqr = 1'b1;
    step; chk_o("reset1", quiet());
    step; chk_o("reset2", quiet());
    initreqr = 1'b0; reset = 1'b1;
    step; chk_o("post_reset", quiet());

    // initreqr from IDLE: one RESET cycle.
    initreqr = 1'b1;
    step; e = quiet(); e.activgreg = 1'b1; e.resetall = 1'b0; chk_o("init_reset", e);
    initreqr = 1'b0;
    step; chk_o("init_idle", quiet());

    // Transmit, 3 cycles of trans.
    tx_head; tx_wait(2); tx_finish;

    // Receive with and without overflow.
    rx_frame(4'b0110, 4'b0010, 1); step; chk_o("rx_idle", quiet());
    rx_frame(4'b0110, 4'b0110, 3); step; chk_o("rx_idle", quiet());
    rx_frame(4'b0000, 4'b0000, 2); step; chk_o("rx_nomatch_idle", quiet());

    // Receive during transmit, 5-cycle frame, then completion.
    tx_head; tx_wait(1);
    rx_frame(4'b0001, 4'b0000, 5);
    step; e = quiet(); e.trans = 1'b1; chk_o("rx_resume", e);
    tx_wait(1); tx_finish;

    // Frame and completion arrive together: straight to TXDONE after the frame.
    tx_head; tx_wait(1);
    sucftranc = 1'b1;
    rx_frame(4'b1000, 4'b0000, 3);
    sucftranc = 1'b0; traregbit = 1'b0;
    step; e = quiet(); e.activtreg = 1'b1; e.activgreg = 1'b1; e.sucftrano = 1'b1; chk_o("pend_done", e);
    step; chk_o("pend_idle", quiet());

    // Timeouts.
    tx_timeout(10, 0);
    tx_timeout(8, 3);

    // initreqr during RXHOLD with a completed transmit pending.
    tx_head;
    sucftranc = 1'b1; sucfrecvc = 1'b1; equal = 4'b0001; rxfull = 4'b0000;
    step; e = quiet(); e.activrreg = 4'b0001; e.ldrecid = 1'b1; e.activgreg = 1'b1; e.sucfrecvo = 1'b1;
    chk_o("init_rxwr", e);
    sucftranc = 1'b0;
    step; chk_o("init_rxhold", quiet());
    initreqr = 1'b1;
    step; e = quiet(); e.activgreg = 1'b1; e.resetall = 1'b0; chk_o("init_rxreset", e);
    initreqr = 1'b0; sucfrecvc = 1'b0; traregbit = 1'b0;
    step; chk_o("init_rx_idle", quiet());
    step; chk_o("no_txdone1", quiet());
    step; chk_o("no_txdone2", quiet());

    // Randomized mix of scenarios.
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: begin
          rx_frame(N'($urandom), N'($urandom), int'($urandom_range(1, 4)));
          step; chk_o("r_rx_idle", quiet());
        end
        1: begin
          tx_head; tx_wait(int'($urandom_range(0, 5))); tx_finish;
        end
        2: begin
          lim = int'($urandom_range(1, 12));
          j   = (lim > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, lim - 1)) : 0;
          tx_timeout(lim, j);
        end
        default: begin
          tx_head; tx_wait(int'($urandom_range(0, 2)));
          rx_frame(N'($urandom), N'($urandom), int'($urandom_range(1, 4)));
          step; e = quiet(); e.trans = 1'b1; chk_o("r_rx_resume", e);
          tx_wait(int'($urandom_range(0, 2))); tx_finish;
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
